// File: rtl/vga_timing_ctrl.sv
// Frame-aligned video timing generator: hsync/vsync/de, pixel coordinates and TMDS period.
// Define VTG_PREAMBLE_EN to schedule HDMI preamble and guard-band periods (DVI mode otherwise).
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        line_start,
  output logic [1:0]  period
);

  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << HW)) begin : g_h_overflow
    $error("vga_timing_ctrl: H_TOTAL exceeds the 11-bit horizontal counter");
  end
  if (V_TOTAL > (1 << VW)) begin : g_v_overflow
    $error("vga_timing_ctrl: V_TOTAL exceeds the 10-bit vertical counter");
  end
`ifdef VTG_PREAMBLE_EN
  if (H_BP < 10) begin : g_bp_short
    $error("vga_timing_ctrl: H_BP must be at least 10 to fit preamble and guard band");
  end
`endif

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VTG_PREAMBLE_EN
  localparam logic [HW-1:0] H_PRE_BEG   = HW'(H_TOTAL - 10);
  localparam logic [HW-1:0] H_GUARD_BEG = HW'(H_TOTAL - 2);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_ACTIVE - 1);
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            enable_q;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            frame_end;

  logic            running_c, hsync_c, vsync_c, de_c, frame_start_c, line_start_c;
  logic [1:0]      period_c;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // State register plus the enable sampling flop that launches and ends frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
    end
  end

  // Next state: start on a sampled enable, stop only on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_q) state_d = ST_RUN;
      ST_RUN:  if (!enable_q && frame_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster counters; held at the origin whenever the controller is not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Output decode of the current counter position, registered one cycle below
  always_comb begin
    running_c     = (state_d == ST_RUN);
    hsync_c       = ~SYNC_POL;
    vsync_c       = ~SYNC_POL;
    de_c          = 1'b0;
    frame_start_c = 1'b0;
    line_start_c  = 1'b0;
    period_c      = 2'd0;
    if (state_q == ST_RUN) begin
      de_c          = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hsync_c       = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_c       = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      frame_start_c = (h_cnt == '0) && (v_cnt == '0);
      line_start_c  = (h_cnt == '0);
      if (de_c) begin
        period_c = 2'd3;
      end
`ifdef VTG_PREAMBLE_EN
      else if ((v_cnt == V_LAST) || (v_cnt < V_ACT_LAST)) begin
        if (h_cnt >= H_GUARD_BEG)    period_c = 2'd2;
        else if (h_cnt >= H_PRE_BEG) period_c = 2'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      period      <= 2'd0;
    end else begin
      running     <= running_c;
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      de          <= de_c;
      x           <= (state_q == ST_RUN) ? h_cnt : '0;
      y           <= (state_q == ST_RUN) ? v_cnt : '0;
      frame_start <= frame_start_c;
      line_start  <= line_start_c;
      period      <= period_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a reduced 100x60 raster (64x48 visible).
module tb_vga_timing_ctrl;

  // Reduced timing: H 64+8+16+12 = 100, V 48+3+2+7 = 60, frame = 6000 cycles
  localparam int H_ACTIVE = 64;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 16;
  localparam int H_BP     = 12;
  localparam int V_ACTIVE = 48;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        running, hsync, vsync, de, frame_start, line_start;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  period;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .running(running),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start), .period(period)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_period(input int ex, input int ey);
    if (ex < 64 && ey < 48) return 3;
`ifdef VTG_PREAMBLE_EN
    if (ey == 59 || ey < 47) begin
      if (ex >= 98) return 2;
      if (ex >= 90) return 1;
    end
`endif
    return 0;
  endfunction

  // Count negedges until frame_start shows, bounded
  task automatic wait_frame_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (frame_start !== 1'b1 && lat < 20);
  endtask

  // Walk one whole frame from a frame_start sample, comparing every pixel to the raster model
  task automatic run_frame(input int drop_y, input int raise_y);
    int cyc = 0, bad = 0, de_n = 0, ln_n = 0, hs_n = 0, vs_n = 0, p1_n = 0, p2_n = 0;
    int ex, ey;
    do begin
      ex = cyc % 100;
      ey = cyc / 100;
      if (x !== 11'(ex) || y !== 10'(ey) || running !== 1'b1 ||
          de !== (ex < 64 && ey < 48) ||
          hsync !== !(ex >= 72 && ex < 88) || vsync !== !(ey >= 51 && ey < 53) ||
          frame_start !== (cyc == 0) || line_start !== (ex == 0) ||
          period !== 2'(exp_period(ex, ey)))
        bad++;
      de_n += int'(de);
      ln_n += int'(line_start);
      hs_n += int'(!hsync);
      vs_n += int'(!vsync);
      p1_n += int'(period == 2'd1);
      p2_n += int'(period == 2'd2);
      if (ex == 50 && ey == drop_y) enable = 1'b0;
      if (ex == 0 && ey == raise_y) enable = 1'b1;
      @(negedge clk);
      cyc++;
    end while (frame_start !== 1'b1 && cyc < 7000);
    check("frame_len", cyc, 6000);
    check("pixel_model_errs", bad, 0);
    check("de_per_frame", de_n, 3072);
    check("lines_per_frame", ln_n, 60);
    check("hsync_low_cycles", hs_n, 960);
    check("vsync_low_cycles", vs_n, 200);
`ifdef VTG_PREAMBLE_EN
    check("preamble_cycles", p1_n, 384);
    check("guard_cycles", p2_n, 96);
`else
    check("preamble_cycles", p1_n, 0);
    check("guard_cycles", p2_n, 0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_running"}, running, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_de"}, de, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_ls"}, line_start, 0);
    check({tag, "_period"}, period, 0);
  endtask

  initial begin
    int lat, n, act;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle");

    // Start: enable sampled at edge k, running from k+1, pixel (0,0) shown at k+2
    enable = 1'b1;
    @(negedge clk);
    check("start_k_running", running, 0);
    @(negedge clk);
    check("start_k1_running", running, 1);
    check("start_k1_fs", frame_start, 0);
    check("start_k1_hsync", hsync, 1);
    check("start_k1_de", de, 0);
    @(negedge clk);
    check("start_k2_fs", frame_start, 1);
    check("start_k2_ls", line_start, 1);
    check("start_k2_de", de, 1);
    check("start_k2_x", x, 0);
    check("start_k2_y", y, 0);
    check("start_k2_period", period, 3);

    run_frame(-1, -1);
    run_frame(-1, -1);

    // Stop request mid-frame: the frame completes, then everything goes idle
    n = 0;
    while (!(x == 11'd50 && y == 10'd20) && n < 7000) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    while (running === 1'b1 && n < 7000) begin
      @(negedge clk);
      n++;
    end
    check("stop_elapsed", n, 5999);
    check("stop_last_x", x, 99);
    check("stop_last_y", y, 59);
    @(negedge clk);
    check_idle_outputs("stopped");
    act = 0;
    repeat (300) begin
      @(negedge clk);
      act += int'(de) + int'(frame_start) + int'(line_start) + int'(running);
    end
    check("idle_activity", act, 0);

    // Restart, then drop and re-raise enable inside one frame: no gap
    enable = 1'b1;
    wait_frame_start(lat);
    check("restart_latency", lat, 3);
    run_frame(10, 30);

    // Asynchronous reset mid-frame at (32,24)
    n = 0;
    while (!(x == 11'd32 && y == 10'd24) && n < 7000) begin
      @(negedge clk);
      n++;
    end
    check("reach_32_24", n < 7000, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_start(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_x", x, 0);
    check("post_rst_y", y, 0);
    check("post_rst_de", de, 1);
    run_frame(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Video timing controller that sequences the pixel pipeline and HDMI output. It generates hsync, vsync, display-enable and pixel coordinates from counters, so DE no longer has to be recovered from the sync edges. Start and stop are frame-aligned. It optionally schedules the HDMI preamble and guard-band periods for the TMDS encoder. It sits in the pixel-clock domain between the PLL/reset logic and both the pattern source and `hdmi_output`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels; must be ≥ 10 when `VTG_PREAMBLE_EN` is defined (elaboration error otherwise)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_POL`, 0: sync active level; 0 = active-low

Ports:
- `clk`  in  1  pixel clock; one clock domain only
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  request to run video timing
- `running`  out  1  controller is in the RUN state
- `hsync`  out  1  horizontal sync, polarity set by `SYNC_POL`
- `vsync`  out  1  vertical sync, polarity set by `SYNC_POL`
- `de`  out  1  visible-area display enable
- `x`  out  11  pixel column (current h count)
- `y`  out  10  pixel row (current v count)
- `frame_start`  out  1  one-cycle pulse at pixel (0,0)
- `line_start`  out  1  one-cycle pulse at x=0 on every line
- `period`  out  2  TMDS period: 0 = control, 1 = preamble, 2 = guard band, 3 = video

## Operation
- H_TOTAL = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800 by default); V_TOTAL = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP` (525 by default).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
  - Counter widths are fixed at 11 bits (h) and 10 bits (v); parameters whose totals exceed these widths are an elaboration error.
- Horizontal regions:
  - active: h < `H_ACTIVE`
  - sync: `H_ACTIVE`+`H_FP` ≤ h < `H_ACTIVE`+`H_FP`+`H_SYNC`
  - The vertical regions follow the same pattern using the V parameters; vsync changes only on lines whose h_cnt = 0.
- `de` = h active AND v active.
- `x`/`y` track h_cnt/v_cnt on every cycle in RUN, including blanking.
- States:
  - IDLE: counters are held at 0; all outputs sit at their inactive values.
  - IDLE → RUN when `enable`=1 is sampled.
  - RUN → IDLE only when `enable`=0 and the counters are at (H_TOTAL-1, V_TOTAL-1). Frames are never truncated.
  - If `enable`=1 at that final pixel, RUN continues into the next frame with no gap.
- Dropping `enable` mid-frame has no effect until the frame ends. Re-raising it before the frame ends cancels the stop.

## Timing
- All outputs are registered. They show the counter value of the previous cycle, and all outputs are mutually aligned.
- Reset values: `running`=0, `de`=0, `x`=0, `y`=0, `frame_start`=0, `line_start`=0, `period`=0, and `hsync`=`vsync`=~`SYNC_POL` (inactive, 1 by default).
- Start latency: `enable` is sampled high at edge k.
  - The counters are at (0,0) from edge k+1.
  - At edge k+2 the outputs show `de`=1, `x`=0, `y`=0, `frame_start`=1, `line_start`=1.
  - `running`=1 from edge k+1.
- Stop timing: the last pixel output is (799,524). `running` falls on the same edge as the counters return to 0, and all outputs are inactive one edge later.
- Reset asserted mid-frame forces the reset values immediately (asynchronous). After release, the block waits in IDLE for `enable`.

## Configuration
- `VTG_PREAMBLE_EN` defined: the controller schedules HDMI periods.
  - This applies on any line whose next line is active, i.e. v_cnt = V_TOTAL-1 or v_cnt < `V_ACTIVE`-1.
  - `period`=1 for h in H_TOTAL-10..H_TOTAL-3 (8 cycles), then `period`=2 for H_TOTAL-2..H_TOTAL-1 (2 cycles).
  - `period`=3 whenever `de`=1; `period`=0 otherwise.
- `VTG_PREAMBLE_EN` undefined: `period`=3 when `de`=1, else 0. Values 1 and 2 never occur (DVI mode).

## Test plan
- Reset then `enable`=1 → `frame_start` two edges later with `x`=0, `y`=0, `de`=1; `hsync`=1 before that pulse.
- Free-run two frames → exactly 800 cycles between `line_start` pulses and 420000 cycles between `frame_start` pulses; exactly 307200 `de` cycles per frame.
- Sync placement → `hsync`=0 exactly for `x`=656..751; `vsync`=0 exactly for `y`=490..491.
- `enable`=0 at (100,200) → timing continues to (799,524), then `running`=0 and `de` stays 0. A second case: re-raise `enable` at (0,300) → no gap between frames.
- `rst_n` pulsed low at (320,240) → all outputs immediately at their reset values; after release with `enable`=1, a clean `frame_start` follows two edges later.
- `VTG_PREAMBLE_EN` defined → at `y`=524, `period`=1 for `x`=790..797 and `period`=2 for `x`=798..799; at `y`=479, only `period`=0 in blanking. Undefined → `period` is never 1 or 2.
